// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared state codes, lamp encodings and direction codes for the
//            intersection scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Controller state codes (also exported on the phase output)
  localparam logic [2:0] ST_NS_G = 3'd0;
  localparam logic [2:0] ST_NS_Y = 3'd1;
  localparam logic [2:0] ST_EW_G = 3'd2;
  localparam logic [2:0] ST_EW_Y = 3'd3;
  localparam logic [2:0] ST_WALK = 3'd4;
  localparam logic [2:0] ST_CLR  = 3'd5;

  // One-hot lamp head encoding {G,Y,R}
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

  // Direction codes
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Lamp shown by a head whose green/yellow states are g_st/y_st
  function automatic logic [2:0] lamp_for(input logic [2:0] st,
                                          input logic [2:0] g_st,
                                          input logic [2:0] y_st);
    if (st == g_st)      return LIGHT_GREEN;
    else if (st == y_st) return LIGHT_YELLOW;
    else                 return LIGHT_RED;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : Per-phase cycle counter. Clears on request, otherwise counts up
//            and holds once it reaches the saturation value.
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_sat_at,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count cycles spent in the current phase, holding at the saturation value
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (r_count < i_sat_at) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : intersection_scheduler
// Brief    : Moore controller sharing one intersection between NS traffic,
//            EW traffic, a pedestrian walk phase and emergency preemption.
// Revision : 1.0 - initial release
// ============================================================================
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES   = 6,
  parameter int YELLOW_CYCLES  = 2,
  parameter int ALL_RED_CYCLES = 1,
  parameter int PED_CYCLES     = 4,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_car_ns,
  input  logic       i_car_ew,
  input  logic       i_ped_req,
  input  logic       i_emerg_req,
  input  logic       i_emerg_dir,
  output logic [2:0] o_light_ns,
  output logic [2:0] o_light_ew,
  output logic       o_walk,
  output logic [2:0] o_phase
);

  // Last timer value of each phase (phase of N cycles ends at N-1)
  localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_clr_last    = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ped_last    = CNT_W'(PED_CYCLES - 1);

  logic [2:0]       r_state;
  logic             r_last_dir;
  logic             r_ped_pend;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_sat_at;
  logic             w_emerg_ns;
  logic             w_emerg_ew;

  assign w_emerg_ns = i_emerg_req && (i_emerg_dir == DIR_NS);
  assign w_emerg_ew = i_emerg_req && (i_emerg_dir == DIR_EW);

  // Timer saturation point for the current phase; a resting green holds here
  always_comb begin
    w_sat_at = c_clr_last;
    case (r_state)
      ST_NS_G, ST_EW_G: w_sat_at = c_green_last;
      ST_NS_Y, ST_EW_Y: w_sat_at = c_yellow_last;
      ST_WALK:          w_sat_at = c_ped_last;
      default:          w_sat_at = c_clr_last;
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_next != r_state),
    .i_sat_at (w_sat_at),
    .o_count  (w_count)
  );

  // Next-state decision: preemption first, then minimum green and demand
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_NS_G: begin
        if (w_emerg_ew) begin
          w_next = ST_NS_Y;
        end else if (!w_emerg_ns && (w_count >= c_green_last) &&
                     (i_car_ew || r_ped_pend)) begin
          w_next = ST_NS_Y;
        end
      end
      ST_EW_G: begin
        if (w_emerg_ns) begin
          w_next = ST_EW_Y;
        end else if (!w_emerg_ew && (w_count >= c_green_last) &&
                     (i_car_ns || r_ped_pend)) begin
          w_next = ST_EW_Y;
        end
      end
      ST_NS_Y, ST_EW_Y: begin
        if (w_count >= c_yellow_last) w_next = ST_CLR;
      end
      ST_WALK: begin
        if (i_emerg_req || (w_count >= c_ped_last)) w_next = ST_CLR;
      end
      ST_CLR: begin
        if (w_count >= c_clr_last) begin
          if (i_emerg_req)               w_next = (i_emerg_dir == DIR_EW) ? ST_EW_G : ST_NS_G;
          else if (r_ped_pend)           w_next = ST_WALK;
          else if (r_last_dir == DIR_EW) w_next = ST_NS_G;
          else                           w_next = ST_EW_G;
        end
      end
      default: w_next = ST_CLR;
    endcase
  end

  // State, last served direction and pending pedestrian request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_CLR;
      r_last_dir <= DIR_EW;
      r_ped_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_NS_Y && r_state != ST_NS_Y) r_last_dir <= DIR_NS;
      if (w_next == ST_EW_Y && r_state != ST_EW_Y) r_last_dir <= DIR_EW;
      // Entering WALK serves the request and absorbs a press in that same cycle
      if (w_next == ST_WALK && r_state != ST_WALK) begin
        r_ped_pend <= 1'b0;
      end else if (i_ped_req && r_state != ST_WALK) begin
        r_ped_pend <= 1'b1;
      end
    end
  end

  assign o_light_ns = lamp_for(r_state, ST_NS_G, ST_NS_Y);
  assign o_light_ew = lamp_for(r_state, ST_EW_G, ST_EW_Y);
  assign o_walk     = (r_state == ST_WALK);
  assign o_phase    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_scheduler
// Brief    : Self-checking bench for intersection_scheduler: directed
//            scenarios with literal expectations plus randomized traffic
//            compared every cycle against a behavioural phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_scheduler;
  import traffic_pkg::*;

  localparam int GREEN  = 6;
  localparam int YELLOW = 2;
  localparam int ALLRED = 1;
  localparam int PED    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_ns = 1'b0, car_ew = 1'b0, ped_req = 1'b0;
  logic       emerg_req = 1'b0, emerg_dir = 1'b0;
  logic [2:0] light_ns, light_ew, phase;
  logic       walk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  intersection_scheduler #(
    .GREEN_CYCLES(GREEN), .YELLOW_CYCLES(YELLOW),
    .ALL_RED_CYCLES(ALLRED), .PED_CYCLES(PED), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_car_ns(car_ns), .i_car_ew(car_ew), .i_ped_req(ped_req),
    .i_emerg_req(emerg_req), .i_emerg_dir(emerg_dir),
    .o_light_ns(light_ns), .o_light_ew(light_ew),
    .o_walk(walk), .o_phase(phase)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phase held plus the number of whole cycles already spent in it.
  logic [2:0] m_ph   = ST_CLR;
  int         m_el   = 0;
  bit         m_last = 1'b1;  // 1 = EW served last
  bit         m_pend = 1'b0;

  function automatic int phase_len(input logic [2:0] ph);
    case (ph)
      ST_NS_Y, ST_EW_Y: return YELLOW;
      ST_WALK:          return PED;
      ST_CLR:           return ALLRED;
      default:          return GREEN;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [2:0] nx;
    bit last_cycle;
    if (reset) begin
      m_ph = ST_CLR; m_el = 0; m_last = 1'b1; m_pend = 1'b0;
    end else begin
      nx = m_ph;
      last_cycle = (m_el + 1 >= phase_len(m_ph));
      case (m_ph)
        ST_NS_G:
          if (emerg_req) begin
            if (emerg_dir) nx = ST_NS_Y;
          end else if (last_cycle && (car_ew || m_pend)) nx = ST_NS_Y;
        ST_EW_G:
          if (emerg_req) begin
            if (!emerg_dir) nx = ST_EW_Y;
          end else if (last_cycle && (car_ns || m_pend)) nx = ST_EW_Y;
        ST_NS_Y, ST_EW_Y: if (last_cycle) nx = ST_CLR;
        ST_WALK: if (emerg_req || last_cycle) nx = ST_CLR;
        default:
          if (last_cycle) begin
            if (emerg_req)   nx = emerg_dir ? ST_EW_G : ST_NS_G;
            else if (m_pend) nx = ST_WALK;
            else             nx = m_last ? ST_NS_G : ST_EW_G;
          end
      endcase
      if (nx == ST_WALK && m_ph != ST_WALK) m_pend = 1'b0;
      else if (ped_req && m_ph != ST_WALK)  m_pend = 1'b1;
      if (nx == ST_NS_Y && m_ph != ST_NS_Y) m_last = 1'b0;
      if (nx == ST_EW_Y && m_ph != ST_EW_Y) m_last = 1'b1;
      m_el = (nx != m_ph) ? 0 : m_el + 1;
      m_ph = nx;
    end
  end

  function automatic logic [2:0] exp_head(input logic [2:0] ph, input bit is_ew);
    if (ph == (is_ew ? ST_EW_G : ST_NS_G)) return 3'b100;
    if (ph == (is_ew ? ST_EW_Y : ST_NS_Y)) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_light_ns", light_ns, exp_head(m_ph, 1'b0));
      chk("model_light_ew", light_ew, exp_head(m_ph, 1'b1));
      chk("model_walk", {2'b00, walk}, {2'b00, m_ph == ST_WALK});
      chk("model_phase", phase, m_ph);
      chk("heads_not_both_open", {2'b00, (light_ns != 3'b001) && (light_ew != 3'b001)}, 3'b000);
      chk("heads_onehot", {1'b0, $onehot(light_ns), $onehot(light_ew)}, 3'b011);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; car_ns = 0; car_ew = 0; ped_req = 0; emerg_req = 0; emerg_dir = 0;
    tick(2);
    reset = 1'b0;   // now at cycle 0 (CLR)
  endtask

  initial begin
    // 1. car_ew held: NS granted first, EW green at cycle 10
    do_reset();
    chk_en = 1'b1;
    chk("t1_reset_ns", light_ns, 3'b001);
    chk("t1_reset_ew", light_ew, 3'b001);
    chk("t1_reset_phase", phase, ST_CLR);
    car_ew = 1;
    tick(1);  chk("t1_ns_green_c1", light_ns, 3'b100);
    tick(6);  chk("t1_ns_yellow_c7", light_ns, 3'b010);
    tick(2);  chk("t1_clr_c9", phase, ST_CLR);
    tick(1);  chk("t1_ew_green_c10", light_ew, 3'b100);

    // 2. no requests: NS green rests
    do_reset();
    tick(51);
    chk("t2_ns_rest", light_ns, 3'b100);
    chk("t2_ew_rest", light_ew, 3'b001);
    chk("t2_phase_rest", phase, ST_NS_G);

    // 3. pedestrian press during NS green
    do_reset();
    tick(3); ped_req = 1; tick(1); ped_req = 0;
    tick(2);  chk("t3_ns_green_c6", light_ns, 3'b100);
    tick(1);  chk("t3_ns_yellow_c7", light_ns, 3'b010);
    tick(3);  chk("t3_walk_c10", {2'b00, walk}, 3'b001);
    chk("t3_walk_ns_red", light_ns, 3'b001);
    chk("t3_walk_ew_red", light_ew, 3'b001);
    tick(3);  chk("t3_walk_c13", {2'b00, walk}, 3'b001);
    tick(1);  chk("t3_clr_c14", phase, ST_CLR);
    tick(1);  chk("t3_ew_green_c15", light_ew, 3'b100);

    // 4. EW emergency preempts NS green, then holds EW
    do_reset();
    tick(2); emerg_req = 1; emerg_dir = 1;
    tick(1);  chk("t4_ns_yellow", light_ns, 3'b010);
    tick(3);  chk("t4_ew_green", light_ew, 3'b100);
    car_ns = 1;
    tick(10); chk("t4_ew_held", light_ew, 3'b100);
    emerg_req = 0;
    tick(1);  chk("t4_ew_yellow", light_ew, 3'b010);
    car_ns = 0;

    // 5. emergency during WALK cycle 1
    do_reset();
    ped_req = 1; tick(1); ped_req = 0;
    tick(10); chk("t5_walk_c1", {2'b00, walk}, 3'b001);
    emerg_req = 1; emerg_dir = 0;
    tick(1);  chk("t5_walk_abort", {2'b00, walk}, 3'b000);
    chk("t5_clr", phase, ST_CLR);
    tick(1);  chk("t5_ns_green", light_ns, 3'b100);
    emerg_req = 0;

    // 6. reset during NS yellow with a pending pedestrian
    do_reset();
    tick(3); ped_req = 1; tick(1); ped_req = 0;
    tick(3);  chk("t6_ns_yellow", light_ns, 3'b010);
    reset = 1;
    tick(1);
    chk("t6_rst_ns", light_ns, 3'b001);
    chk("t6_rst_ew", light_ew, 3'b001);
    chk("t6_rst_walk", {2'b00, walk}, 3'b000);
    reset = 0;
    tick(1);  chk("t6_first_grant_ns", phase, ST_NS_G);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      car_ns  = ($urandom_range(0, 99) < 30);
      car_ew  = ($urandom_range(0, 99) < 30);
      ped_req = ($urandom_range(0, 99) < 4);
      if (emerg_req) begin
        if ($urandom_range(0, 99) < 10) emerg_req = 0;
      end else if ($urandom_range(0, 99) < 2) begin
        emerg_req = 1;
        emerg_dir = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 999) < 3);
      tick(1);
    end
    reset = 0; car_ns = 0; car_ew = 0; ped_req = 0; emerg_req = 0;
    tick(2);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
